branch_predict_unit: RTL and testbench

- Next-generation branch decision block for the 5-stage MIPS pipeline.
- Resolves conditional branches and jumps in D, like the existing comparator, and adds a direct-mapped table of 2-bit saturating counters.
- F-stage lookup gives the predicted direction; D-stage resolution drives the PC mux, flags mispredicts and trains the table.
- Sits between the GRF/forwarding muxes (D operands) and the NPC/PC-select logic.

---
 rtl/branch_predict_unit_if.sv | 27 ++
 rtl/branch_predict_unit.sv | 152 +++++++++++++++
 tb/tb_branch_predict_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_unit_if.sv
// Branch predict unit bus: F-stage lookup plus the D-stage resolve/train group.
// master = pipeline side, slave = branch_predict_unit.
interface branch_predict_unit_if #(
    parameter int unsigned DATA_W = 32
);
    logic [31:0]       f_pc;
    logic              f_pred_taken;
    logic              d_valid;
    logic              d_stall;
    logic [31:0]       d_pc;
    logic [2:0]        branch;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic              d_pred_taken;
    logic [2:0]        PC_sel;
    logic              mispredict;

    modport master (
        output f_pc, d_valid, d_stall, d_pc, branch, RD1, RD2, d_pred_taken,
        input  f_pred_taken, PC_sel, mispredict
    );

    modport slave (
        input  f_pc, d_valid, d_stall, d_pc, branch, RD1, RD2, d_pred_taken,
        output f_pred_taken, PC_sel, mispredict
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch predict unit: D-stage branch/jump resolution with a direct-mapped table
// of 2-bit saturating counters looked up in F and trained in D.
// Optional macro BRANCH_STATS_EN adds saturating branch/mispredict counters.
module branch_predict_unit #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BHT_DEPTH = 64,
    localparam int unsigned IDX_W    = $clog2(BHT_DEPTH)
) (
    input  logic clk,
    input  logic reset,
`ifdef BRANCH_STATS_EN
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts,
`endif
    branch_predict_unit_if.slave bus
);
    localparam logic [2:0] BrNone = 3'd0;
    localparam logic [2:0] BrBeq  = 3'd1;
    localparam logic [2:0] BrJal  = 3'd2;
    localparam logic [2:0] BrJr   = 3'd3;
    localparam logic [2:0] BrBne  = 3'd4;
    localparam logic [2:0] BrJ    = 3'd5;
    localparam logic [2:0] BrBgez = 3'd6;
    localparam logic [2:0] BrBltz = 3'd7;

    localparam logic [2:0] SelPc4     = 3'b000;
    localparam logic [2:0] SelBranch  = 3'b001;
    localparam logic [2:0] SelJal     = 3'b010;
    localparam logic [2:0] SelReg     = 3'b011;
    localparam logic [2:0] SelJ       = 3'b100;
    localparam logic [2:0] SelRecover = 3'b101;

    logic [1:0]       bht_q [BHT_DEPTH];
    logic [1:0]       bht_d [BHT_DEPTH];
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] d_idx;
    logic [1:0]       d_cnt;
    logic             active;
    logic             cond;
    logic             taken;
    logic             upd;
    logic             unused_pc;

    assign f_idx  = bus.f_pc[IDX_W+1:2];
    assign d_idx  = bus.d_pc[IDX_W+1:2];
    assign d_cnt  = bht_q[d_idx];
    assign active = bus.d_valid & ~bus.d_stall;
    assign upd    = active & cond;

    // Only the index bits of the PCs feed the table.
    assign unused_pc = ^{bus.f_pc[31:IDX_W+2], bus.f_pc[1:0],
                         bus.d_pc[31:IDX_W+2], bus.d_pc[1:0]};

    // No bypass: F sees the registered counter even when D updates it this cycle.
    assign bus.f_pred_taken = bht_q[f_idx][1];

    // Decode conditional branches and evaluate their condition.
    always_comb begin
        cond  = 1'b0;
        taken = 1'b0;
        case (bus.branch)
            BrBeq:  begin cond = 1'b1; taken = (bus.RD1 == bus.RD2); end
            BrBne:  begin cond = 1'b1; taken = (bus.RD1 != bus.RD2); end
            BrBgez: begin cond = 1'b1; taken = ~bus.RD1[DATA_W-1]; end
            BrBltz: begin cond = 1'b1; taken = bus.RD1[DATA_W-1]; end
            default: begin cond = 1'b0; taken = 1'b0; end
        endcase
    end

    // PC select and mispredict; everything idles on invalid or stalled slots.
    always_comb begin
        bus.PC_sel     = SelPc4;
        bus.mispredict = 1'b0;
        if (active) begin
            if (cond) begin
                bus.mispredict = (taken != bus.d_pred_taken);
                if (taken && !bus.d_pred_taken) begin
                    bus.PC_sel = SelBranch;
                end else if (!taken && bus.d_pred_taken) begin
                    // Delay slot at d_pc+4 was already fetched down the wrong path.
                    bus.PC_sel = SelRecover;
                end else begin
                    bus.PC_sel = SelPc4;
                end
            end else begin
                case (bus.branch)
                    BrJal:   bus.PC_sel = SelJal;
                    BrJr:    bus.PC_sel = SelReg;
                    BrJ:     bus.PC_sel = SelJ;
                    BrNone:  bus.PC_sel = SelPc4;
                    default: bus.PC_sel = SelPc4;
                endcase
            end
        end
    end

    // Next table state: saturating train of the D-stage entry.
    always_comb begin
        bht_d = bht_q;
        if (upd) begin
            if (taken) begin
                bht_d[d_idx] = (d_cnt == 2'b11) ? 2'b11 : d_cnt + 2'd1;
            end else begin
                bht_d[d_idx] = (d_cnt == 2'b00) ? 2'b00 : d_cnt - 2'd1;
            end
        end
    end

    // Table register; reset forces weakly not-taken and wins over any update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            bht_q <= bht_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_br_d;
    logic [31:0] stat_mis_q;
    logic [31:0] stat_mis_d;

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;

    // Saturating event counters.
    always_comb begin
        stat_br_d  = stat_br_q;
        stat_mis_d = stat_mis_q;
        if (upd && stat_br_q != 32'hFFFF_FFFF) begin
            stat_br_d = stat_br_q + 32'd1;
        end
        if (bus.mispredict && !bus.d_stall && stat_mis_q != 32'hFFFF_FFFF) begin
            stat_mis_d = stat_mis_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_br_q  <= 32'd0;
            stat_mis_q <= 32'd0;
        end else begin
            stat_br_q  <= stat_br_d;
            stat_mis_q <= stat_mis_d;
        end
    end
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed vectors push expected
// responses into a queue, a negedge monitor pops and compares them.
module tb_branch_predict_unit;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    branch_predict_unit_if #(.DATA_W(32)) bus ();

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_predict_unit #(
        .DATA_W    (32),
        .BHT_DEPTH (64)
    ) dut (
        .clk              (clk),
        .reset            (reset),
`ifdef BRANCH_STATS_EN
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
`endif
        .bus              (bus)
    );

    typedef struct {
        string       name;
        logic [2:0]  pc_sel;
        logic        misp;
        logic        fpred;
        int          cidx;
        logic [1:0]  cval;
        logic        chk_stat;
        logic [31:0] sb;
        logic [31:0] sm;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Pending stats expectation attached to the next step.
    logic        pend_stat = 1'b0;
    logic [31:0] pend_sb   = 32'd0;
    logic [31:0] pend_sm   = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: outputs are stable at the negedge following each driven step.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, ".PC_sel"}, {29'd0, bus.PC_sel}, {29'd0, e.pc_sel});
            chk({e.name, ".mispredict"}, {31'd0, bus.mispredict}, {31'd0, e.misp});
            chk({e.name, ".f_pred_taken"}, {31'd0, bus.f_pred_taken}, {31'd0, e.fpred});
            if (e.cidx >= 0) begin
                chk({e.name, ".counter"}, {30'd0, dut.bht_q[e.cidx]}, {30'd0, e.cval});
            end
`ifdef BRANCH_STATS_EN
            if (e.chk_stat) begin
                chk({e.name, ".stat_branches"}, stat_branches, e.sb);
                chk({e.name, ".stat_mispredicts"}, stat_mispredicts, e.sm);
            end
`endif
        end
    end

    task automatic step(input string name, input logic [31:0] fpc, input logic v,
                        input logic s, input logic [31:0] dpc, input logic [2:0] br,
                        input logic [31:0] r1, input logic [31:0] r2, input logic pr,
                        input logic [2:0] e_sel, input logic e_mis, input logic e_fp,
                        input int cidx, input logic [1:0] cval);
        exp_t e;
        @(posedge clk);
        #1;
        bus.f_pc         = fpc;
        bus.d_valid      = v;
        bus.d_stall      = s;
        bus.d_pc         = dpc;
        bus.branch       = br;
        bus.RD1          = r1;
        bus.RD2          = r2;
        bus.d_pred_taken = pr;
        e.name = name; e.pc_sel = e_sel; e.misp = e_mis; e.fpred = e_fp;
        e.cidx = cidx; e.cval = cval;
        e.chk_stat = pend_stat; e.sb = pend_sb; e.sm = pend_sm;
        pend_stat = 1'b0;
        q.push_back(e);
    endtask

    task automatic want_stats(input logic [31:0] sb, input logic [31:0] sm);
        pend_stat = 1'b1;
        pend_sb   = sb;
        pend_sm   = sm;
    endtask

    // One reset cycle with a coincident taken beq at 0x3004 that must be discarded.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset            = 1'b1;
        bus.f_pc         = 32'h3004;
        bus.d_valid      = 1'b1;
        bus.d_stall      = 1'b0;
        bus.d_pc         = 32'h3004;
        bus.branch       = 3'd1;
        bus.RD1          = 32'd9;
        bus.RD2          = 32'd9;
        bus.d_pred_taken = 1'b0;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        bus.d_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset            = 1'b1;
        bus.f_pc         = 32'h0;
        bus.d_valid      = 1'b0;
        bus.d_stall      = 1'b0;
        bus.d_pc         = 32'h0;
        bus.branch       = 3'd0;
        bus.RD1          = 32'h0;
        bus.RD2          = 32'h0;
        bus.d_pred_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state: every counter weakly not-taken.
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            chk("reset.counter", {30'd0, dut.bht_q[i]}, 32'd1);
        end

        //    name         f_pc      v  s  d_pc      br    RD1           RD2    pr  sel     mis fp  idx cval
        step("idle",       32'h3000, 0, 0, 32'h3000, 3'd0, 32'd0,        32'd0, 0, 3'b000, 0, 0, 0,  2'b01);
        step("beq1",       32'h3004, 1, 0, 32'h3004, 3'd1, 32'd5,        32'd5, 0, 3'b001, 1, 0, 1,  2'b01);
        step("beq2",       32'h3004, 1, 0, 32'h3004, 3'd1, 32'd5,        32'd5, 0, 3'b001, 1, 1, 1,  2'b10);
        step("beq3",       32'h3004, 1, 0, 32'h3004, 3'd1, 32'd5,        32'd5, 1, 3'b000, 0, 1, 1,  2'b11);
        step("sat",        32'h3004, 0, 0, 32'h3004, 3'd0, 32'd0,        32'd0, 0, 3'b000, 0, 1, 1,  2'b11);
        step("bne_mis",    32'h3004, 1, 0, 32'h3004, 3'd4, 32'd7,        32'd7, 1, 3'b101, 1, 1, 1,  2'b11);
        step("bne_stall",  32'h3004, 1, 1, 32'h3004, 3'd4, 32'd7,        32'd7, 1, 3'b000, 0, 1, 1,  2'b10);
        want_stats(32'd4, 32'd3);
        step("chk10",      32'h3004, 0, 0, 32'h3004, 3'd0, 32'd0,        32'd0, 0, 3'b000, 0, 1, 1,  2'b10);
        step("jal",        32'h3004, 1, 0, 32'h3004, 3'd2, 32'd1,        32'd2, 1, 3'b010, 0, 1, 1,  2'b10);
        step("jr",         32'h3004, 1, 0, 32'h3004, 3'd3, 32'd1,        32'd1, 1, 3'b011, 0, 1, 1,  2'b10);
        step("j",          32'h3004, 1, 0, 32'h3004, 3'd5, 32'd1,        32'd1, 1, 3'b100, 0, 1, 1,  2'b10);
        step("none",       32'h3004, 1, 0, 32'h3004, 3'd0, 32'd1,        32'd1, 1, 3'b000, 0, 1, 1,  2'b10);
        step("jmp_keep",   32'h3004, 0, 0, 32'h3004, 3'd0, 32'd0,        32'd0, 0, 3'b000, 0, 1, 1,  2'b10);
        step("bgez_neg",   32'h3010, 1, 0, 32'h3010, 3'd6, 32'h80000000, 32'd0, 0, 3'b000, 0, 0, 4,  2'b01);
        step("bltz_neg1",  32'h3010, 1, 0, 32'h3010, 3'd7, 32'h80000000, 32'd0, 0, 3'b001, 1, 0, 4,  2'b00);
        // Same-cycle lookup sees 01 while D moves it to 10.
        step("bltz_neg2",  32'h3010, 1, 0, 32'h3010, 3'd7, 32'h80000000, 32'd0, 0, 3'b001, 1, 0, 4,  2'b01);
        step("after_upd",  32'h3010, 0, 0, 32'h3010, 3'd0, 32'd0,        32'd0, 0, 3'b000, 0, 1, 4,  2'b10);
        step("bgez_pos",   32'h3020, 1, 0, 32'h3020, 3'd6, 32'd5,        32'd0, 1, 3'b000, 0, 0, 8,  2'b01);
        step("invalid",    32'h3020, 0, 0, 32'h3020, 3'd1, 32'd3,        32'd3, 0, 3'b000, 0, 1, 8,  2'b10);
        step("inv_keep",   32'h3020, 0, 0, 32'h3020, 3'd0, 32'd0,        32'd0, 0, 3'b000, 0, 1, 8,  2'b10);

        // Mid-training reset discards history and beats the coincident update.
        do_reset();
        want_stats(32'd0, 32'd0);
        step("rst_3004",   32'h3004, 0, 0, 32'h3004, 3'd0, 32'd0,        32'd0, 0, 3'b000, 0, 0, 1,  2'b01);
        step("rst_3010",   32'h3010, 0, 0, 32'h3010, 3'd0, 32'd0,        32'd0, 0, 3'b000, 0, 0, 4,  2'b01);

        // Four branches, two mispredicts.
        step("s_beq_t",    32'h3040, 1, 0, 32'h3040, 3'd1, 32'd1,        32'd1, 0, 3'b001, 1, 0, 16, 2'b01);
        step("s_beq_n",    32'h3040, 1, 0, 32'h3040, 3'd1, 32'd1,        32'd2, 0, 3'b000, 0, 1, 16, 2'b10);
        step("s_bne_t",    32'h3040, 1, 0, 32'h3040, 3'd4, 32'd1,        32'd2, 1, 3'b000, 0, 0, 16, 2'b01);
        step("s_bne_n",    32'h3040, 1, 0, 32'h3040, 3'd4, 32'd3,        32'd3, 1, 3'b101, 1, 1, 16, 2'b10);
        want_stats(32'd4, 32'd2);
        step("s_check",    32'h3040, 0, 0, 32'h3040, 3'd0, 32'd0,        32'd0, 0, 3'b000, 0, 0, 16, 2'b01);

        do_reset();
        want_stats(32'd0, 32'd0);
        step("s_cleared",  32'h3040, 0, 0, 32'h3040, 3'd0, 32'd0,        32'd0, 0, 3'b000, 0, 0, 16, 2'b01);

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
